pipe_delay_bank: RTL and testbench

Parametrised multi-channel pipeline delay bank with valid tracking, stall, flush and a selectable intermediate tap. It replaces the hand-written chains of staging registers (1-, 2- and 3-cycle delayed copies of ALU result, register read data, PC+1) in the processor datapath. One instance aligns CHANNELS operand buses to a common DEPTH-cycle latency, and the tap port exposes any earlier stage.

---
 rtl/pipe_delay_bank.sv | 93 +++++++++
 tb/tb_pipe_delay_bank.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_delay_bank.sv
// Multi-channel delay line: DEPTH stages of {valid, CHANNELS*WIDTH data}
// shifting in lockstep, with stall/flush, a selectable tap and an occupancy count.
module pipe_delay_bank #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 3,
  parameter int CHANNELS = 4,
  localparam int TAPW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCCW    = $clog2(DEPTH + 1),
  localparam int DW      = CHANNELS * WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  input  logic [TAPW-1:0] tap_sel,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            tap_valid,
  output logic [DW-1:0]   tap_data,
  output logic [OCCW-1:0] occupancy
);

  // in_valid qualifies in_data on every edge; there is no ready. A word
  // presented while stall or flush is high is dropped and must be re-presented,
  // and the word leaving the last stage is discarded without a downstream ack.

  // Index 0 is stage 1 (fed from the inputs); index DEPTH-1 drives out_*.
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
    end else if (!stall) begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = out_valid ? data_q[DEPTH-1] : '0;

  // Out-of-range tap indices match no stage and leave the tap invalid.
  logic          tap_v;
  logic [DW-1:0] tap_d;

  always_comb begin
    tap_v = 1'b0;
    tap_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (TAPW'(i) == tap_sel) begin
        tap_v = valid_q[i];
        tap_d = data_q[i];
      end
    end
  end

  assign tap_valid = tap_v;
  assign tap_data  = tap_v ? tap_d : '0;

  logic [OCCW-1:0] occ;

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCCW'(valid_q[i]);
    end
  end

  assign occupancy = occ;

endmodule

// File: tb/tb_pipe_delay_bank.sv
// Directed bench for pipe_delay_bank (WIDTH=32, DEPTH=3, CHANNELS=2):
// reset, streaming, stall, flush, tap range and bubbles.
module tb_pipe_delay_bank;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 3;
  localparam int CHANNELS = 2;
  localparam int TAPW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCCW     = $clog2(DEPTH + 1);
  localparam int DW       = CHANNELS * WIDTH;

  logic            clk;
  logic            reset;
  logic            stall;
  logic            flush;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic [TAPW-1:0] tap_sel;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            tap_valid;
  logic [DW-1:0]   tap_data;
  logic [OCCW-1:0] occupancy;

  int checks;
  int failures;

  logic [DW-1:0] exp_q[$];

  pipe_delay_bank #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CHANNELS(CHANNELS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .tap_sel(tap_sel),
    .out_valid(out_valid),
    .out_data(out_data),
    .tap_valid(tap_valid),
    .tap_data(tap_data),
    .occupancy(occupancy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] c0, input logic [31:0] c1);
    in_valid = v;
    in_data  = {c1, c0};
  endtask

  task automatic drain();
    drive(1'b0, 32'h0, 32'h0);
    stall = 1'b0;
    flush = 1'b0;
    repeat (DEPTH) step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1'b1, 32'hAA, 32'hBB); step();
    drive(1'b1, 32'hCC, 32'hDD); step();
    drive(1'b1, 32'hEE, 32'hFF); step();
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== {32'hBB, 32'hAA}) begin
      failures++;
      $display("FAIL reset_preload: out_valid=%b out_data=%h expected 1 %h", out_valid, out_data, {32'hBB, 32'hAA});
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_out: out_valid=%b out_data=%h expected 0 0", out_valid, out_data);
    end
    checks++;
    if (tap_valid !== 1'b0 || tap_data !== '0) begin
      failures++;
      $display("FAIL reset_tap: tap_valid=%b tap_data=%h expected 0 0", tap_valid, tap_data);
    end
    checks++;
    if (occupancy !== '0) begin
      failures++;
      $display("FAIL reset_occ: occupancy=%0d expected 0", occupancy);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_stream();
    logic [DW-1:0] got;
    tap_sel = 2'd0;
    drive(1'b1, 32'h11, 32'h22); exp_q.push_back({32'h22, 32'h11}); step();
    checks++;
    if (tap_valid !== 1'b1 || tap_data !== {32'h22, 32'h11} || occupancy !== 2'd1) begin
      failures++;
      $display("FAIL stream_e1: tap_valid=%b tap_data=%h occ=%0d expected 1 %h 1", tap_valid, tap_data, occupancy, {32'h22, 32'h11});
    end
    drive(1'b1, 32'h33, 32'h44); exp_q.push_back({32'h44, 32'h33}); step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd2) begin
      failures++;
      $display("FAIL stream_e2: out_valid=%b occ=%0d expected 0 2", out_valid, occupancy);
    end
    drive(1'b1, 32'h55, 32'h66); exp_q.push_back({32'h66, 32'h55}); step();
    checks++;
    if (occupancy !== 2'd3) begin
      failures++;
      $display("FAIL stream_e3_occ: occ=%0d expected 3", occupancy);
    end
    drive(1'b0, 32'h0, 32'h0);
    for (int n = 0; n < DEPTH; n++) begin
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== got) begin
          failures++;
          $display("FAIL stream_out%0d: out_valid=%b out_data=%h expected 1 %h", n, out_valid, out_data, got);
        end
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || occupancy !== '0) begin
      failures++;
      $display("FAIL stream_drained: out_valid=%b occ=%0d expected 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h0A, 32'h1A); step();
    drive(1'b1, 32'h0B, 32'h1B); step();
    tap_sel = 2'd1;
    stall = 1'b1;
    drive(1'b1, 32'h99, 32'h99);
    for (int n = 0; n < 2; n++) begin
      step();
      checks++;
      if (occupancy !== 2'd2 || out_valid !== 1'b0 || tap_data !== {32'h1A, 32'h0A}) begin
        failures++;
        $display("FAIL stall_hold%0d: occ=%0d out_valid=%b tap_data=%h expected 2 0 %h", n, occupancy, out_valid, tap_data, {32'h1A, 32'h0A});
      end
    end
    tap_sel = 2'd0;
    #1;
    checks++;
    if (tap_data !== {32'h1B, 32'h0B}) begin
      failures++;
      $display("FAIL stall_stage1: tap_data=%h expected %h", tap_data, {32'h1B, 32'h0B});
    end
    stall = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== {32'h1A, 32'h0A}) begin
      failures++;
      $display("FAIL stall_first_out: out_valid=%b out_data=%h expected 1 %h", out_valid, out_data, {32'h1A, 32'h0A});
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== {32'h1B, 32'h0B}) begin
      failures++;
      $display("FAIL stall_second_out: out_valid=%b out_data=%h expected 1 %h", out_valid, out_data, {32'h1B, 32'h0B});
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== '0) begin
      failures++;
      $display("FAIL stall_no99: out_valid=%b out_data=%h occ=%0d expected 0 0 0", out_valid, out_data, occupancy);
    end
  endtask

  task automatic test_flush();
    tap_sel = 2'd0;
    drive(1'b1, 32'hC1, 32'hD1); step();
    drive(1'b1, 32'hC2, 32'hD2); step();
    drive(1'b1, 32'hC3, 32'hD3); step();
    checks++;
    if (occupancy !== 2'd3 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_pre: occ=%0d out_valid=%b expected 3 1", occupancy, out_valid);
    end
    flush = 1'b1;
    stall = 1'b1;
    drive(1'b1, 32'h77, 32'h77);
    step();
    checks++;
    if (occupancy !== '0 || out_valid !== 1'b0 || out_data !== '0 || tap_valid !== 1'b0 || tap_data !== '0) begin
      failures++;
      $display("FAIL flush_clear: occ=%0d out_valid=%b out_data=%h tap_valid=%b tap_data=%h expected all 0",
               occupancy, out_valid, out_data, tap_valid, tap_data);
    end
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b1, 32'hDE, 32'hAD); step();
    drive(1'b0, 32'h0, 32'h0);
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd1) begin
      failures++;
      $display("FAIL flush_refill_e2: out_valid=%b occ=%0d expected 0 1", out_valid, occupancy);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== {32'hAD, 32'hDE}) begin
      failures++;
      $display("FAIL flush_refill_out: out_valid=%b out_data=%h expected 1 %h", out_valid, out_data, {32'hAD, 32'hDE});
    end
    drain();
  endtask

  task automatic test_tap_range();
    drive(1'b1, 32'hE1, 32'hF1); step();
    drive(1'b1, 32'hE2, 32'hF2); step();
    drive(1'b1, 32'hE3, 32'hF3); step();
    drive(1'b0, 32'h0, 32'h0);
    tap_sel = 2'd2;
    #1;
    checks++;
    if (tap_valid !== 1'b1 || tap_data !== {32'hF1, 32'hE1} || out_data !== {32'hF1, 32'hE1}) begin
      failures++;
      $display("FAIL tap_last: tap_valid=%b tap_data=%h out_data=%h expected 1 %h", tap_valid, tap_data, out_data, {32'hF1, 32'hE1});
    end
    tap_sel = 2'd1;
    #1;
    checks++;
    if (tap_valid !== 1'b1 || tap_data !== {32'hF2, 32'hE2}) begin
      failures++;
      $display("FAIL tap_mid: tap_valid=%b tap_data=%h expected 1 %h", tap_valid, tap_data, {32'hF2, 32'hE2});
    end
    tap_sel = 2'd3;
    #1;
    checks++;
    if (tap_valid !== 1'b0 || tap_data !== '0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL tap_oob: tap_valid=%b tap_data=%h out_valid=%b expected 0 0 1", tap_valid, tap_data, out_valid);
    end
    tap_sel = 2'd0;
    drain();
  endtask

  task automatic test_bubbles();
    logic          in_v   [8];
    logic [31:0]   in_c0  [8];
    logic          exp_v  [8];
    logic [DW-1:0] exp_d  [8];
    logic [OCCW-1:0] exp_o[8];
    in_v  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    in_c0 = '{32'hA, 32'hB, 32'hC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_d = '{64'h0, 64'h0, 64'hA, 64'h0, 64'hC, 64'h0, 64'h0, 64'h0};
    exp_o = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    for (int n = 0; n < 6; n++) begin
      drive(in_v[n], in_c0[n], 32'h0);
      step();
      checks++;
      if (out_valid !== exp_v[n] || out_data !== exp_d[n] || occupancy !== exp_o[n]) begin
        failures++;
        $display("FAIL bubble_e%0d: out_valid=%b out_data=%h occ=%0d expected %b %h %0d",
                 n + 1, out_valid, out_data, occupancy, exp_v[n], exp_d[n], exp_o[n]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    tap_sel  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_tap_range();
    test_bubbles();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
